mat_result_drain: RTL
=====================

// Module: mat_result_drain
// PURPOSE
//  Downstream of the matching top level. Snapshots the 16-slot matched-address bus
//  (position, 16 x 15-bit frame-buffer addresses) on each rising edge of isMatching.
//  Streams the non-empty slots, lowest slot first, over a valid/ready interface
//  toward the result/host side.
//  Decouples the free-running matcher from a consumer that may stall.
// PARAMETERS
//  SLOTS   16  number of address slots on the position bus
//  ADDR_W  15  width of one frame-buffer address; slot i = position[i*ADDR_W +: ADDR_W]
//  CNT_W   5   width of matchCount; must hold SLOTS
// PORTS
//  clock       in   1        system clock; all state updates on the rising edge
//  nReset      in   1        asynchronous active-low reset
//  position    in   240      SLOTS*ADDR_W matched addresses; value 0 = empty slot
//  isMatching  in   1        matcher result flag; a rising edge triggers a capture
//  outReady    in   1        consumer accepts the current beat
//  clrOverrun  in   1        synchronous clear of the overrun flag
//  outValid    out  1        outAddr/outIndex/outLast valid
//  outAddr     out  15       matched frame-buffer address
//  outIndex    out  4        slot number of outAddr
//  outLast     out  1        current beat is the final non-empty slot of the snapshot
//  drainDone   out  1        one-cycle pulse: snapshot fully delivered
//  busy        out  1        high in SEND and DONE
//  matchCount  out  5        number of non-empty slots in the latest snapshot
//  overrun     out  1        sticky: a capture trigger arrived while busy
// BEHAVIOUR
//  Reset (nReset=0, async): state=IDLE. The registers snapshot, mask, matchCount and
//   prevMatch are 0. All outputs are 0.
//  Edge detect: prevMatch <= isMatching every cycle; trigger = isMatching & ~prevMatch.
//   Because prevMatch resets to 0, isMatching held high across reset release triggers
//   on the first edge.
//  FSM states: IDLE, SEND, DONE.
//  IDLE + trigger, at the capturing edge:
//   - snapshot <= position.
//   - mask[i] <= (slot i != 0).
//   - matchCount <= popcount(mask).
//   - Next state: SEND if any bit is set, else DONE.
//  SEND:
//   - outValid = 1.
//   - Selected slot = lowest set bit of mask (combinational priority encode).
//   - outIndex = that slot number; outAddr = snapshot slot at outIndex.
//   - outLast = (popcount(mask) == 1).
//   - Latency: the first beat is valid in the cycle immediately after the capturing
//     edge. Empty slots never cost cycles.
//  Handshake: a beat transfers on an edge where outValid & outReady.
//   - On transfer, mask[outIndex] <= 0. If the cleared bit was the last one, go to DONE.
//   - Otherwise the next beat is presented the following cycle; outValid stays high,
//     no bubble.
//   - With outReady=0, outValid, outAddr, outIndex and outLast hold stable. outValid
//     never drops before its transfer.
//  DONE: drainDone = 1 for exactly one cycle, outValid = 0, then go to IDLE.
//   A trigger during DONE is treated as an overrun and is not captured.
//  Overrun:
//   - trigger while state != IDLE sets overrun <= 1. snapshot, mask and matchCount
//     are unchanged; that result is dropped.
//   - clrOverrun clears overrun; a simultaneous new overrun event wins (flag stays 1).
//   - overrun is not cleared by a capture.
//  busy = (state != IDLE). matchCount holds until the next capture.
//  Reset mid-SEND aborts immediately. The partial snapshot is discarded; no drainDone
//   is produced.
//  position changes after capture have no effect; only the snapshot is streamed.
// TESTING
//  T1 reset:
//   - Stimulus: nReset low with random inputs.
//   - Response: every output is 0 while low and stays 0 after release with isMatching=0.
//  T2 basic drain:
//   - Stimulus: slots 2, 5 and 15 = 0x0123, 0x1F40 and 0x4AFF, other slots 0;
//     isMatching 0->1; outReady=1.
//   - Response: three consecutive beats (idx 2, 5, 15). outLast only on idx 15.
//     drainDone pulses the next cycle. matchCount=3.
//  T3 backpressure:
//   - Stimulus: as T2, with outReady=0 for 4 cycles on the first beat.
//   - Response: outValid=1 and outAddr=0x0123 held for all 4 cycles; then normal
//     completion.
//  T4 empty snapshot:
//   - Stimulus: position all 0, isMatching rises.
//   - Response: outValid is never asserted. drainDone pulses 1 cycle after the
//     capture. matchCount=0.
//  T5 overrun:
//   - Stimulus: isMatching falls and rises again mid-SEND with new position.
//   - Response: overrun=1 and the old beats continue unchanged. clrOverrun=1 for
//     one cycle clears the flag.
//  T6 reset mid-drain:
//   - Stimulus: nReset asserted after the first beat of a 16-slot full snapshot.
//   - Response: outputs are 0 asynchronously. After release with isMatching=1, a
//     fresh capture happens on the first edge.

Source files
------------

// File: rtl/mat_result_drain_if.sv
// Handshake bundle between the matcher, the result drain and its consumer.
//   position/isMatching/clrOverrun : matcher side inputs to the drain
//   outValid/outReady/outAddr/outIndex/outLast : beat stream toward the host
//   drainDone/busy/matchCount/overrun : drain status
// slave  : the drain itself
// master : whatever drives the matcher bus and consumes the beat stream
interface mat_result_drain_if #(
    parameter int SLOTS  = 16,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 5
);
    localparam int IDX_W = $clog2(SLOTS);

    logic [SLOTS*ADDR_W-1:0] position;
    logic                    isMatching;
    logic                    outReady;
    logic                    clrOverrun;
    logic                    outValid;
    logic [ADDR_W-1:0]       outAddr;
    logic [IDX_W-1:0]        outIndex;
    logic                    outLast;
    logic                    drainDone;
    logic                    busy;
    logic [CNT_W-1:0]        matchCount;
    logic                    overrun;

    modport slave (
        input  position, isMatching, outReady, clrOverrun,
        output outValid, outAddr, outIndex, outLast,
        output drainDone, busy, matchCount, overrun
    );

    modport master (
        output position, isMatching, outReady, clrOverrun,
        input  outValid, outAddr, outIndex, outLast,
        input  drainDone, busy, matchCount, overrun
    );
endinterface

// File: rtl/mat_result_drain.sv
// mat_result_drain
// Captures the matched-address bus on each rising edge of isMatching and
// streams the non-empty slots, lowest slot first, over a valid/ready link.
// Ports:
//   clock  : system clock, rising edge
//   nReset : asynchronous active-low reset
//   bus    : mat_result_drain_if.slave (matcher inputs, beat stream, status)
module mat_result_drain #(
    parameter int SLOTS  = 16,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 5
) (
    input  logic               clock,
    input  logic               nReset,
    mat_result_drain_if.slave  bus
);
    localparam int IDX_W = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                         state;
    logic [SLOTS-1:0][ADDR_W-1:0]   slot_in;
    logic [SLOTS-1:0][ADDR_W-1:0]   snap;
    logic [SLOTS-1:0]               nz;
    logic [SLOTS-1:0]               mask;
    logic [SLOTS-1:0]               sel_oh;
    logic [SLOTS-1:0]               rest;
    logic [IDX_W-1:0]               sel_idx;
    logic [CNT_W-1:0]               cnt_q;
    logic                           prev_match;
    logic                           trigger;
    logic                           valid_q;
    logic                           done_q;
    logic                           busy_q;
    logic                           ovr_q;
    logic                           xfer;
    logic                           last;

    function automatic logic [CNT_W-1:0] popcnt(input logic [SLOTS-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < SLOTS; i++) c = c + CNT_W'(m[i]);
        return c;
    endfunction

    assign slot_in = bus.position;

    // Per-slot empty detect: address 0 marks an unused slot.
    for (genvar g = 0; g < SLOTS; g++) begin : g_nz
        assign nz[g] = |slot_in[g];
    end

    assign trigger = bus.isMatching & ~prev_match;

    // Lowest set bit of the pending mask selects the current beat.
    assign sel_oh = mask & (~mask + SLOTS'(1));
    assign rest   = mask & ~sel_oh;
    assign last   = (mask != '0) && (rest == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) sel_idx = IDX_W'(i);
        end
    end

    assign xfer = valid_q & bus.outReady;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            snap       <= '0;
            mask       <= '0;
            cnt_q      <= '0;
            prev_match <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            prev_match <= bus.isMatching;

            // A new event in the same cycle as a clear keeps the flag set.
            if (trigger && state != IDLE) ovr_q <= 1'b1;
            else if (bus.clrOverrun)      ovr_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        snap   <= slot_in;
                        mask   <= nz;
                        cnt_q  <= popcnt(nz);
                        busy_q <= 1'b1;
                        if (nz != '0) begin
                            state   <= SEND;
                            valid_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        mask <= rest;
                        if (last) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Beat fields are forced to zero outside SEND so idle outputs stay clean.
    assign bus.outValid   = valid_q;
    assign bus.outIndex   = valid_q ? sel_idx : '0;
    assign bus.outAddr    = valid_q ? snap[sel_idx] : '0;
    assign bus.outLast    = valid_q & last;
    assign bus.drainDone  = done_q;
    assign bus.busy       = busy_q;
    assign bus.matchCount = cnt_q;
    assign bus.overrun    = ovr_q;

    a_stall_hold: assert property (@(posedge clock) disable iff (!nReset)
        bus.outValid && !bus.outReady |=> bus.outValid && $stable(bus.outAddr)
                                          && $stable(bus.outIndex));
    a_done_pulse: assert property (@(posedge clock) disable iff (!nReset)
        bus.drainDone |=> !bus.drainDone);
endmodule
